// File: rtl/bus_server_mem_if.sv
// bus_server_mem_if: server-side bus between the 4-client arbiter and the memory server.
// Signals: server_rq/server_address/server_wr_ni/server_dataW driven by the arbiter (master),
//          server_ack/server_dataR driven by the memory server (slave).
interface bus_server_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  server_rq;
    logic [ADDR_WIDTH-1:0] server_address;
    logic                  server_wr_ni;
    logic [DATA_WIDTH-1:0] server_dataW;
    logic                  server_ack;
    logic [DATA_WIDTH-1:0] server_dataR;

    modport master (
        output server_rq, server_address, server_wr_ni, server_dataW,
        input  server_ack, server_dataR
    );

    modport slave (
        input  server_rq, server_address, server_wr_ni, server_dataW,
        output server_ack, server_dataR
    );
endinterface

// File: rtl/bus_server_mem.sv
// bus_server_mem: word-addressed memory server with four-phase rq/ack handshake and wait states.
// Ports: clk, reset (async, active-high), bus (slave side of bus_server_mem_if),
//        addr_err (one-cycle pulse on an out-of-range access).
// Optional: define BUS_SERVER_MEM_STATS_EN to add saturating 16-bit rd_count/wr_count outputs.
module bus_server_mem #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    bus_server_mem_if.slave bus,
    output logic addr_err
`ifdef BUS_SERVER_MEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_q, eff_addr;
    logic                  wr_q, eff_wr;
    logic [DATA_WIDTH-1:0] dw_q, eff_dw;
    logic                  access, in_range;
    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // With zero wait states the access happens on the accepting edge, before the
    // request registers hold anything, so the live bus is used in IDLE.
    assign eff_addr = (state == IDLE) ? bus.server_address : addr_q;
    assign eff_wr   = (state == IDLE) ? bus.server_wr_ni   : wr_q;
    assign eff_dw   = (state == IDLE) ? bus.server_dataW   : dw_q;
    assign in_range = {1'b0, eff_addr} < (ADDR_WIDTH+1)'(MEM_DEPTH);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        access  = 1'b0;
        case (state)
            IDLE: if (bus.server_rq) begin
                if (WAIT_STATES == 0) begin
                    state_n = ACK;
                    access  = 1'b1;
                end else begin
                    state_n = WAIT;
                    cnt_n   = 4'(WAIT_STATES - 1);
                end
            end
            WAIT: begin
                if (!bus.server_rq) state_n = IDLE;
                else if (cnt != 4'd0) cnt_n = cnt - 4'd1;
                else begin
                    state_n = ACK;
                    access  = 1'b1;
                end
            end
            ACK: if (!bus.server_rq) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            addr_q           <= '0;
            wr_q             <= 1'b0;
            dw_q             <= '0;
            bus.server_ack   <= 1'b0;
            bus.server_dataR <= '0;
            addr_err         <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            addr_err <= access && !in_range;
            if (state == IDLE && bus.server_rq) begin
                addr_q <= bus.server_address;
                wr_q   <= bus.server_wr_ni;
                dw_q   <= bus.server_dataW;
            end
            if (access) begin
                bus.server_ack   <= 1'b1;
                bus.server_dataR <= (in_range && !eff_wr) ? mem[eff_addr] : '0;
                if (in_range && eff_wr) mem[eff_addr] <= eff_dw;
            end else if (state == ACK && !bus.server_rq) begin
                bus.server_ack   <= 1'b0;
                bus.server_dataR <= '0;
            end
        end
    end

`ifdef BUS_SERVER_MEM_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (access) begin
            if (!eff_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (eff_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end
`endif
endmodule
